instr_dcd: RTL and testbench
============================

INSTR_DCD -- requirements
Module: instr_dcd

Interface
REQ-001 SHALL: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  reset, asynchronous and active-low.
REQ-003 SHALL: byte_sync  input  1  one-cycle strobe from SPI bridge; data_in holds a complete byte while high.
REQ-004 SHALL: data_in  input  8  byte received from SPI (command or write data).
REQ-005 SHALL: data_out  output  8  byte returned to SPI (read data).
REQ-006 SHALL: read  output  1  register-file read enable (level).
REQ-007 SHALL: write  output  1  register-file write enable (level).
REQ-008 SHALL: addr  output  6  register address.
REQ-009 SHALL: data_read  input  8  data supplied by register file for addr.
REQ-010 SHALL: data_write  output  8  data presented to register file.

Function
REQ-011 SHALL: two-state FSM, CMD and DATA; one state change per clk edge with byte_sync=1; no change when byte_sync=0.
REQ-012 SHALL: command byte layout: bit7 RW (1=write, 0=read), bit6 HI flag, bits5:0 address.
REQ-013 SHALL: in CMD with byte_sync=1: latch RW, HI, address; set cmd_valid=1; go to DATA.
REQ-014 SHALL: in DATA with byte_sync=1 and RW=1: data_write <= data_in; go to CMD.
REQ-015 SHALL: in DATA with byte_sync=1 and RW=0: internal read buffer <= data_read; go to CMD.
REQ-016 SHALL: data_out = read buffer (registered); data_write = write register (registered); both hold until overwritten.
REQ-017 SHALL: write = cmd_valid AND RW; read = cmd_valid AND NOT RW; both combinational from latched command.
REQ-018 SHALL: read/write remain asserted after the data byte, until the next command byte replaces the latched command or reset.
REQ-019 SHALL: addr = latched address when HI=1, else 6'h00.
REQ-020 SHALL: outputs reflect a newly latched command/data value in the cycle after the byte_sync edge (1-cycle latency).
REQ-021 SHALL: byte_sync held high N cycles counts as N bytes, alternating CMD/DATA.
REQ-022 SHALL: data_in ignored when byte_sync=0; data_read sampled only on DATA-phase read byte.

Reset
REQ-023 SHALL: rst_n low asynchronously forces state=CMD, cmd_valid=0, RW=0, HI=0, address=0, buffers=0.
REQ-024 SHALL: during/after reset until first command: read=0, write=0, addr=0, data_out=0, data_write=0.
REQ-025 SHALL: reset mid-transaction discards the pending command; next byte after release is a command.

Structure
REQ-026 SHALL: shared package holds FSM state enum, command bit positions (RW=7, HI=6, ADDR=5:0), widths (data 8, addr 6).
REQ-027 SHALL: single flat module; no sub-module.

Verification
REQ-028 SHALL: reset, cmd 0xCF (W,HI,addr 0x0F) -> write=1 read=0 addr=0x0F; data 0xAA -> write=1, data_write=0xAA.
REQ-029 SHALL: reset, cmd 0x6A (R,HI,addr 0x2A) -> read=1 write=0 addr=0x2A; data_read=0xCC then sync -> data_out=0xCC, read=1.
REQ-030 SHALL: reset, cmd 0xBF (W,LO,addr 0x3F) -> write=1 read=0 addr=0x00; data 0x55 -> data_write=0x55.
REQ-031 SHALL: back-to-back: cmd 0xC1, data 0x11, cmd 0x42, data_read=0x22 sync -> addr 0x01 then 0x02, data_write=0x11, data_out=0x22, write->read switch.
REQ-032 SHALL: cmd 0xC5 then rst_n pulse before data -> outputs all 0; next byte 0x7F decoded as command (read, addr 0x3F).

Source files
------------

// File: rtl/instr_dcd_pkg.sv
// Shared definitions for the SPI command/data decoder: FSM states,
// command byte field positions and datapath widths.
package instr_dcd_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 6;

    localparam int unsigned CMD_RW_BIT   = 7;
    localparam int unsigned CMD_HI_BIT   = 6;
    localparam int unsigned CMD_ADDR_MSB = 5;
    localparam int unsigned CMD_ADDR_LSB = 0;

    typedef enum logic {
        ST_CMD  = 1'b0,
        ST_DATA = 1'b1
    } state_e;

endpackage

// File: rtl/instr_dcd_if.sv
// SPI-bridge byte stream and register-file access signals of the decoder.
interface instr_dcd_if;
    import instr_dcd_pkg::*;

    logic              byte_sync;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_read;
    logic [DATA_W-1:0] data_write;

    modport master (
        input  byte_sync, data_in, data_read,
        output data_out, read, write, addr, data_write
    );

    modport slave (
        output byte_sync, data_in, data_read,
        input  data_out, read, write, addr, data_write
    );

endinterface

// File: rtl/instr_dcd.sv
// Decodes alternating command/data bytes from the SPI bridge into
// register-file read/write strobes, address and data.
module instr_dcd
    import instr_dcd_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    instr_dcd_if.master  bus
);

    state_e            state_q;
    logic              cmd_valid_q;
    logic              rw_q;
    logic              hi_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] rd_buf_q;
    logic [DATA_W-1:0] wr_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CMD;
            cmd_valid_q <= 1'b0;
            rw_q        <= 1'b0;
            hi_q        <= 1'b0;
            addr_q      <= '0;
            rd_buf_q    <= '0;
            wr_data_q   <= '0;
        end else if (bus.byte_sync) begin
            unique case (state_q)
                ST_CMD: begin
                    cmd_valid_q <= 1'b1;
                    rw_q        <= bus.data_in[CMD_RW_BIT];
                    hi_q        <= bus.data_in[CMD_HI_BIT];
                    addr_q      <= bus.data_in[CMD_ADDR_MSB:CMD_ADDR_LSB];
                    state_q     <= ST_DATA;
                end
                ST_DATA: begin
                    // Latched command stays valid so read/write persist until the next command.
                    if (rw_q) begin
                        wr_data_q <= bus.data_in;
                    end else begin
                        rd_buf_q  <= bus.data_read;
                    end
                    state_q <= ST_CMD;
                end
            endcase
        end
    end

    assign bus.write      = cmd_valid_q & rw_q;
    assign bus.read       = cmd_valid_q & ~rw_q;
    assign bus.addr       = hi_q ? addr_q : '0;
    assign bus.data_out   = rd_buf_q;
    assign bus.data_write = wr_data_q;

endmodule

// File: tb/tb_instr_dcd.sv
// Randomized self-checking bench for instr_dcd against a byte-stream model.
module tb_instr_dcd;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    // Reference model: byte stream interpreted directly from the command rules.
    bit         m_expect_cmd;
    bit         m_valid;
    logic [7:0] m_cmd;
    logic [7:0] m_wdata;
    logic [7:0] m_rbuf;

    instr_dcd_if bus ();

    instr_dcd dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_expect_cmd = 1'b1;
        m_valid      = 1'b0;
        m_cmd        = 8'h00;
        m_wdata      = 8'h00;
        m_rbuf       = 8'h00;
    endtask

    task automatic model_clock();
        if (rst_n && bus.byte_sync) begin
            if (m_expect_cmd) begin
                m_cmd   = bus.data_in;
                m_valid = 1'b1;
            end else if (m_cmd >= 8'd128) begin
                m_wdata = bus.data_in;
            end else begin
                m_rbuf  = bus.data_read;
            end
            m_expect_cmd = !m_expect_cmd;
        end
    endtask

    task automatic check_all(input string tag);
        int exp_addr;
        exp_addr = ((m_cmd / 64) % 2 == 1) ? (m_cmd % 64) : 0;
        check({tag, ".write"},      32'(bus.write),      32'(m_valid && m_cmd >= 8'd128));
        check({tag, ".read"},       32'(bus.read),       32'(m_valid && m_cmd < 8'd128));
        check({tag, ".addr"},       32'(bus.addr),       32'(exp_addr));
        check({tag, ".data_out"},   32'(bus.data_out),   32'(m_rbuf));
        check({tag, ".data_write"}, 32'(bus.data_write), 32'(m_wdata));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_clock();
        #1;
        check_all(tag);
    endtask

    task automatic send(input logic [7:0] b, input logic [7:0] rd);
        bus.byte_sync = 1'b1;
        bus.data_in   = b;
        bus.data_read = rd;
        step("send");
        bus.byte_sync = 1'b0;
        bus.data_in   = 8'($urandom);
        bus.data_read = 8'($urandom);
    endtask

    // Asserts reset mid-cycle so the asynchronous clear is observed before any edge.
    task automatic do_reset();
        bus.byte_sync = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        n_total       = 0;
        n_bad         = 0;
        rst_n         = 1'b1;
        bus.byte_sync = 1'b0;
        bus.data_in   = 8'h00;
        bus.data_read = 8'h00;
        model_reset();
        #3;
        do_reset();

        check("reset.read",  32'(bus.read),  32'd0);
        check("reset.write", 32'(bus.write), 32'd0);

        send(8'hCF, 8'h00);
        check("w_hi.write", 32'(bus.write), 32'd1);
        check("w_hi.read",  32'(bus.read),  32'd0);
        check("w_hi.addr",  32'(bus.addr),  32'h0F);
        send(8'hAA, 8'h00);
        check("w_hi.data_write", 32'(bus.data_write), 32'hAA);
        check("w_hi.write2",     32'(bus.write),      32'd1);

        do_reset();
        send(8'h6A, 8'h00);
        check("r_hi.read", 32'(bus.read), 32'd1);
        check("r_hi.addr", 32'(bus.addr), 32'h2A);
        send(8'h13, 8'hCC);
        check("r_hi.data_out", 32'(bus.data_out), 32'hCC);
        check("r_hi.read2",    32'(bus.read),     32'd1);

        do_reset();
        send(8'hBF, 8'h00);
        check("w_lo.write", 32'(bus.write), 32'd1);
        check("w_lo.addr",  32'(bus.addr),  32'h00);
        send(8'h55, 8'h00);
        check("w_lo.data_write", 32'(bus.data_write), 32'h55);

        do_reset();
        send(8'hC1, 8'h00);
        check("b2b.addr1", 32'(bus.addr), 32'h01);
        send(8'h11, 8'h00);
        send(8'h42, 8'h00);
        check("b2b.addr2", 32'(bus.addr),  32'h02);
        check("b2b.read",  32'(bus.read),  32'd1);
        check("b2b.write", 32'(bus.write), 32'd0);
        send(8'h00, 8'h22);
        check("b2b.data_out",   32'(bus.data_out),   32'h22);
        check("b2b.data_write", 32'(bus.data_write), 32'h11);

        do_reset();
        send(8'hC5, 8'h00);
        do_reset();
        check("mid_rst.write", 32'(bus.write), 32'd0);
        check("mid_rst.addr",  32'(bus.addr),  32'h00);
        send(8'h7F, 8'h00);
        check("mid_rst.read",   32'(bus.read),  32'd1);
        check("mid_rst.write2", 32'(bus.write), 32'd0);
        check("mid_rst.addr2",  32'(bus.addr),  32'h3F);

        // Random byte stream with idle gaps, back-to-back strobes and occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) < 2) begin
                do_reset();
            end else begin
                bus.byte_sync = ($urandom_range(99) < 55);
                bus.data_in   = 8'($urandom);
                bus.data_read = 8'($urandom);
                step("rand");
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
